demux1t8_stream: RTL and testbench
==================================

Name: demux1t8_stream

Overview:
- Registered 1-to-8 stream demultiplexer with valid/ready handshakes.
- Routes each accepted word from one upstream producer to exactly one of 8 downstream consumers, chosen by a 3-bit select.
- Counterpart to the 8-to-1 selector used in the datapath. Used wherever a single result source (for example the write-back or forwarding bus) must be distributed to one of 8 sinks with backpressure.
- One-entry holding stage: 1-cycle latency, full throughput.

Parameters:
- WIDTH, 32, data width of in_data and out_data.
- CNT_WIDTH, 16, width of each per-channel transfer counter (used only with DEMUX_CNT_EN).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous discard of the held word.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_sel  input  3  destination channel 0..7.
- in_data  input  WIDTH  upstream word.
- out_valid  output  8  one-hot (or zero) valid per channel.
- out_ready  input  8  per-channel downstream ready.
- out_data  output  WIDTH  shared data bus to all channels.
- Interface decisions: one clock, clk. Reset rst_n is asynchronous and active-low.

Behaviour:
- State is hold_vld (1b), hold_sel (3b) and hold_data (WIDTH).
- Reset (rst_n=0, asynchronous):
  - hold_vld=0, hold_sel=0, hold_data=0.
  - out_valid=8'h00, out_data=0, in_ready=0 while rst_n low.
  - in_ready=1 from the first cycle after release.
  - Reset mid-transfer discards the held word. Nothing is delivered.
- Outputs:
  - out_valid = hold_vld ? (8'b1 << hold_sel) : 8'h00. Never more than one bit set.
  - out_data = hold_data, registered, with no combinational path from in_data.
- Handshake signals:
  - drain = hold_vld & out_ready[hold_sel]. Ready bits of unselected channels are ignored.
  - in_ready = ~flush & (~hold_vld | drain). This is combinational from out_ready and flush.
  - accept = in_valid & in_ready.
- Next state, evaluated in priority order:
  - flush=1: hold_vld <= 0. No accept. If drain was also true that cycle, the transfer still counts as delivered.
  - accept=1: hold_vld <= 1, hold_sel <= in_sel, hold_data <= in_data. This covers a simultaneous drain and accept, which sustains 1 word/cycle.
  - drain=1 without accept: hold_vld <= 0. hold_data is retained but not valid.
  - Otherwise: hold.
- Latency: a word accepted at edge k appears on out_valid/out_data after edge k and can drain in that same cycle.
- Stability: while out_valid[c]=1 and out_ready[c]=0, out_valid and out_data hold constant. The block never withdraws valid except via flush or reset.
- Back-to-back words to different channels: out_valid switches one-hot directly on the edge, with no idle cycle between.
- Head-of-line: a stalled channel blocks all channels. This is by design; there is no reordering.
- Upstream obligation: keep in_sel and in_data stable while in_valid & ~in_ready. The block does not depend on this for correctness.

Optional Feature:
- Macro: DEMUX_CNT_EN.
- When defined, add ports:
  - cnt_clr  input  1
  - cnt_rd_sel  input  3
  - cnt_rd_val  output  CNT_WIDTH
- Counter rules:
  - 8 counters, reset to 0.
  - counter[hold_sel] increments on each drain, saturating at all-ones with no wrap.
  - cnt_clr=1 zeroes all counters. Clear wins over a same-cycle increment.
  - cnt_rd_val = counter[cnt_rd_sel], combinational.
- When undefined: ports and counters are absent, and datapath behaviour is identical.

Test Plan:
- Reset then single word: in_sel=5, in_data=32'hDEADBEEF, out_ready=8'hFF.
  - Expect out_valid=8'h20 and out_data=DEADBEEF one cycle later, then out_valid=0.
- Streaming: 8 words to sel 0..7 back-to-back with all ready.
  - Expect in_ready held at 1, out_valid walking 01,02,...,80 on consecutive cycles, and no bubbles.
- Backpressure: word to sel 3, out_ready=8'hF7 for 4 cycles, then 8'hFF.
  - Expect out_valid=8'h08 and data stable for 4 cycles and in_ready=0.
  - The next word is accepted in the drain cycle.
- Flush: hold word for sel 2 with out_ready[2]=0, assert flush one cycle.
  - Expect in_ready=0 that cycle, then out_valid=0.
  - The next word (sel 6, 32'h1234) is delivered normally.
- Async reset mid-hold: word held for sel 1, drop rst_n between edges.
  - Expect out_valid=0 and out_data=0 immediately, with no delivery after release.
- With DEMUX_CNT_EN and CNT_WIDTH=2: 5 drains on ch4.
  - Expect cnt_rd_val=3 (saturated) with cnt_rd_sel=4.
  - cnt_clr concurrent with a drain gives 0.

Source files
------------

// File: rtl/demux1t8_stream.sv
// -----------------------------------------------------------------------------
// demux1t8_stream
//   Registered 1-to-8 stream demultiplexer with valid/ready handshakes.
//   Each accepted upstream word is held in a one-entry stage and presented to
//   exactly one of 8 downstream channels selected by in_sel. There is one
//   cycle of latency and full throughput, because a word can drain and be
//   replaced in the same cycle.
//
//   Optional feature (macro DEMUX_CNT_EN):
//     8 saturating per-channel transfer counters, with a clear input and a
//     combinational read port.
//
// Parameters:
//   WIDTH      data width of in_data / out_data
//   CNT_WIDTH  width of each per-channel transfer counter (DEMUX_CNT_EN only)
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   flush       synchronous discard of the held word
//   in_valid    upstream word valid
//   in_ready    block can accept a word this cycle (combinational)
//   in_sel      destination channel 0..7
//   in_data     upstream word
//   out_valid   one-hot (or zero) valid per channel
//   out_ready   per-channel downstream ready
//   out_data    shared data bus to all channels
//   cnt_clr     zero all transfer counters        (DEMUX_CNT_EN only)
//   cnt_rd_sel  counter read select               (DEMUX_CNT_EN only)
//   cnt_rd_val  selected counter value, comb.     (DEMUX_CNT_EN only)
// -----------------------------------------------------------------------------
module demux1t8_stream #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_sel,
    input  logic [WIDTH-1:0]     in_data,
    output logic [7:0]           out_valid,
    input  logic [7:0]           out_ready,
`ifdef DEMUX_CNT_EN
    input  logic                 cnt_clr,
    input  logic [2:0]           cnt_rd_sel,
    output logic [CNT_WIDTH-1:0] cnt_rd_val,
`endif
    output logic [WIDTH-1:0]     out_data
);

    localparam int unsigned NUM_CH = 8;

    // A counter narrower than one bit cannot hold a transfer count.
    if (CNT_WIDTH < 1) begin : g_bad_cnt_width
        $error("demux1t8_stream: CNT_WIDTH must be at least 1");
    end

    // Holding stage.
    logic             r_hold_vld;
    logic [2:0]       r_hold_sel;
    logic [WIDTH-1:0] r_hold_data;

    // Low while in reset and held low until the first edge after release.
    logic             r_rdy;

    logic             w_drain;
    logic             w_accept;

    // Unselected channels' ready bits are deliberately ignored.
    assign w_drain  = r_hold_vld & out_ready[r_hold_sel];
    assign in_ready = r_rdy & ~flush & (~r_hold_vld | w_drain);
    assign w_accept = in_valid & in_ready;

    // Decoded from registers only, so there is no path from the inputs.
    assign out_valid = r_hold_vld ? (NUM_CH'(1) << r_hold_sel) : NUM_CH'(0);
    assign out_data  = r_hold_data;

    // Reset-done flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy <= 1'b0;
        end else begin
            r_rdy <= 1'b1;
        end
    end

    // Holding stage update. Flush has priority; in_ready already excludes an
    // accept during flush. An accept covers the simultaneous drain case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_vld  <= 1'b0;
            r_hold_sel  <= 3'd0;
            r_hold_data <= '0;
        end else if (flush) begin
            r_hold_vld  <= 1'b0;
        end else if (w_accept) begin
            r_hold_vld  <= 1'b1;
            r_hold_sel  <= in_sel;
            r_hold_data <= in_data;
        end else if (w_drain) begin
            r_hold_vld  <= 1'b0;
        end
    end

`ifdef DEMUX_CNT_EN
    // Per-channel delivered-word counters. A drain in a flush cycle still
    // counts, because the consumer took the word.
    logic [CNT_WIDTH-1:0] r_cnt [NUM_CH];
    logic                 w_cnt_sat;

    assign w_cnt_sat  = (r_cnt[r_hold_sel] == {CNT_WIDTH{1'b1}});
    assign cnt_rd_val = r_cnt[cnt_rd_sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                r_cnt[i] <= '0;
            end
        end else if (cnt_clr) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_drain && !w_cnt_sat) begin
            r_cnt[r_hold_sel] <= r_cnt[r_hold_sel] + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_demux1t8_stream.sv
// -----------------------------------------------------------------------------
// tb_demux1t8_stream
//   Directed self-checking bench for demux1t8_stream: reset values, single
//   word, streaming, backpressure, flush, asynchronous reset while a word is
//   held, and (with DEMUX_CNT_EN) counter saturation and clear priority.
// -----------------------------------------------------------------------------
module tb_demux1t8_stream;

    localparam int unsigned WIDTH = 32;
`ifdef DEMUX_CNT_EN
    localparam int unsigned CNT_WIDTH = 2;
`else
    localparam int unsigned CNT_WIDTH = 16;
`endif

    logic                 clk;
    logic                 rst_n;
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           in_sel;
    logic [WIDTH-1:0]     in_data;
    logic [7:0]           out_valid;
    logic [7:0]           out_ready;
    logic [WIDTH-1:0]     out_data;
`ifdef DEMUX_CNT_EN
    logic                 cnt_clr;
    logic [2:0]           cnt_rd_sel;
    logic [CNT_WIDTH-1:0] cnt_rd_val;
`endif

    int n_tests;
    int n_fail;

    demux1t8_stream #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef DEMUX_CNT_EN
        .cnt_clr    (cnt_clr),
        .cnt_rd_sel (cnt_rd_sel),
        .cnt_rd_val (cnt_rd_val),
`endif
        .out_data   (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 3'd0;
        in_data   = '0;
        out_ready = 8'h00;
`ifdef DEMUX_CNT_EN
        cnt_clr    = 1'b0;
        cnt_rd_sel = 3'd0;
`endif

        // Reset values
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'h00);
        check("rst_out_data",  64'(out_data),  64'h0);
        check("rst_in_ready",  64'(in_ready),  64'h0);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", 64'(in_ready), 64'h1);

        // Single word to channel 5
        out_ready = 8'hFF;
        in_valid  = 1'b1;
        in_sel    = 3'd5;
        in_data   = 32'hDEADBEEF;
        #1 check("single_in_ready", 64'(in_ready), 64'h1);
        tick();
        in_valid = 1'b0;
        check("single_out_valid", 64'(out_valid), 64'h20);
        check("single_out_data",  64'(out_data),  64'hDEADBEEF);
        tick();
        check("single_drained", 64'(out_valid), 64'h00);
        check("single_data_kept", 64'(out_data), 64'hDEADBEEF);

        // Streaming 0..7 back-to-back
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_sel   = 3'(i);
            in_data  = 32'h100 + 32'(i);
            #1 check("stream_in_ready", 64'(in_ready), 64'h1);
            tick();
            check("stream_out_valid", 64'(out_valid), 64'(8'h01 << i));
            check("stream_out_data",  64'(out_data),  64'h100 + 64'(i));
        end
        in_valid = 1'b0;
        tick();
        check("stream_idle", 64'(out_valid), 64'h00);

        // Backpressure on channel 3, next word waits upstream
        out_ready = 8'hF7;
        in_valid  = 1'b1;
        in_sel    = 3'd3;
        in_data   = 32'hA5A5A5A5;
        tick();
        in_sel  = 3'd6;
        in_data = 32'h00000077;
        #1;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) tick();
            check("bp_out_valid", 64'(out_valid), 64'h08);
            check("bp_out_data",  64'(out_data),  64'hA5A5A5A5);
            check("bp_in_ready",  64'(in_ready),  64'h0);
        end
        out_ready = 8'hFF;
        #1 check("bp_drain_in_ready", 64'(in_ready), 64'h1);
        tick();
        in_valid = 1'b0;
        check("bp_next_valid", 64'(out_valid), 64'h40);
        check("bp_next_data",  64'(out_data),  64'h77);
        tick();
        check("bp_idle", 64'(out_valid), 64'h00);

        // Flush a word stalled on channel 2; a word offered during flush is refused
        out_ready = 8'hFB;
        in_valid  = 1'b1;
        in_sel    = 3'd2;
        in_data   = 32'h22;
        tick();
        in_valid = 1'b0;
        check("flush_held", 64'(out_valid), 64'h04);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_sel   = 3'd7;
        in_data  = 32'h99;
        #1 check("flush_in_ready", 64'(in_ready), 64'h0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_cleared", 64'(out_valid), 64'h00);
        out_ready = 8'hFF;
        in_valid  = 1'b1;
        in_sel    = 3'd6;
        in_data   = 32'h1234;
        tick();
        in_valid = 1'b0;
        check("flush_next_valid", 64'(out_valid), 64'h40);
        check("flush_next_data",  64'(out_data),  64'h1234);
        tick();
        check("flush_next_idle", 64'(out_valid), 64'h00);

        // Asynchronous reset while channel 1 holds a word
        out_ready = 8'hFD;
        in_valid  = 1'b1;
        in_sel    = 3'd1;
        in_data   = 32'h1111;
        tick();
        in_valid = 1'b0;
        check("arst_held", 64'(out_valid), 64'h02);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'h00);
        check("arst_out_data",  64'(out_data),  64'h0);
        check("arst_in_ready",  64'(in_ready),  64'h0);
        out_ready = 8'hFF;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("arst_no_delivery", 64'(out_valid), 64'h00);
        check("arst_in_ready_up", 64'(in_ready),  64'h1);
        tick();
        check("arst_still_idle", 64'(out_valid), 64'h00);

`ifdef DEMUX_CNT_EN
        // Five drains on channel 4 saturate a 2-bit counter at 3
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_sel   = 3'd4;
            in_data  = 32'h4000 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        cnt_rd_sel = 3'd4;
        #1 check("cnt_ch4_sat", 64'(cnt_rd_val), 64'h3);
        cnt_rd_sel = 3'd0;
        #1 check("cnt_ch0_zero", 64'(cnt_rd_val), 64'h0);

        // Clear wins over a same-cycle drain
        out_ready = 8'hEF;
        in_valid  = 1'b1;
        in_sel    = 3'd4;
        in_data   = 32'h4444;
        tick();
        in_valid  = 1'b0;
        cnt_clr   = 1'b1;
        out_ready = 8'hFF;
        tick();
        cnt_clr    = 1'b0;
        cnt_rd_sel = 3'd4;
        #1 check("cnt_clr_wins", 64'(cnt_rd_val), 64'h0);
        check("cnt_clr_drained", 64'(out_valid), 64'h00);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
